// File: rtl/retire_pair_buffer.sv
// Retire pair buffer: two per-core retire FIFOs released to the checker only as aligned pairs.
// Raises per-core stall requests one entry before full and reports skew, drain and overflow.
module retire_pair_buffer #(
    parameter int DEPTH = 4,
    parameter int REC_W = 96,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             retire_1_i,
    input  logic [REC_W-1:0] rec_1_i,
    input  logic             retire_2_i,
    input  logic [REC_W-1:0] rec_2_i,
    input  logic             pair_ready_i,
    output logic             pair_valid_o,
    output logic [REC_W-1:0] rec_1_o,
    output logic [REC_W-1:0] rec_2_o,
    output logic             stall_1_o,
    output logic             stall_2_o,
    output logic [CW:0]      skew_o,
    output logic             drained_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [2][DEPTH];
    logic [AW-1:0]    wptr [2];
    logic [AW-1:0]    rptr [2];
    logic [CW-1:0]    count [2];
    logic [REC_W-1:0] rec_in [2];
    logic [1:0]       retire;
    logic [1:0]       push;
    logic [1:0]       drop;
    logic [1:0]       nonempty;
    logic             pop;
    logic             overflow_q;

    assign retire    = {retire_2_i, retire_1_i};
    assign rec_in[0] = rec_1_i;
    assign rec_in[1] = rec_2_i;

    assign nonempty[0] = (count[0] != '0);
    assign nonempty[1] = (count[1] != '0);

    assign pair_valid_o = nonempty[0] && nonempty[1];
    assign pop          = pair_valid_o && pair_ready_i;

    // A full FIFO still accepts a push when the same edge frees a slot.
    always_comb begin
        push = '0;
        drop = '0;
        for (int i = 0; i < 2; i++) begin
            if (retire[i]) begin
                if ((count[i] != CW'(DEPTH)) || pop) begin
                    push[i] = 1'b1;
                end else begin
                    drop[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 2; i++) begin
                wptr[i]  <= '0;
                rptr[i]  <= '0;
                count[i] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wptr[i] <= wptr[i] + 1'b1;
                end
                if (pop) begin
                    rptr[i] <= rptr[i] + 1'b1;
                end
                count[i] <= count[i] + CW'(push[i]) - CW'(pop);
            end
            if (drop != '0) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage needs no reset: heads are masked while a FIFO is empty.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wptr[i]] <= rec_in[i];
            end
        end
    end

    assign rec_1_o    = nonempty[0] ? mem[0][rptr[0]] : '0;
    assign rec_2_o    = nonempty[1] ? mem[1][rptr[1]] : '0;
    assign stall_1_o  = (count[0] >= CW'(DEPTH - 1));
    assign stall_2_o  = (count[1] >= CW'(DEPTH - 1));
    assign skew_o     = {1'b0, count[0]} - {1'b0, count[1]};
    assign drained_o  = !nonempty[0] && !nonempty[1];
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_retire_pair_buffer.sv
// Directed testbench for retire_pair_buffer (DEPTH=4, REC_W=96).
// Expected values are hand-computed constants and record tags.
module tb_retire_pair_buffer;

    localparam int DEPTH = 4;
    localparam int REC_W = 96;
    localparam int CW    = 3;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             retire_1_i = 1'b0;
    logic [REC_W-1:0] rec_1_i = '0;
    logic             retire_2_i = 1'b0;
    logic [REC_W-1:0] rec_2_i = '0;
    logic             pair_ready_i = 1'b0;
    logic             pair_valid_o;
    logic [REC_W-1:0] rec_1_o;
    logic [REC_W-1:0] rec_2_o;
    logic             stall_1_o;
    logic             stall_2_o;
    logic [CW:0]      skew_o;
    logic             drained_o;
    logic             overflow_o;

    int total = 0;
    int bad   = 0;

    retire_pair_buffer #(.DEPTH(DEPTH), .REC_W(REC_W)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .retire_1_i   (retire_1_i),
        .rec_1_i      (rec_1_i),
        .retire_2_i   (retire_2_i),
        .rec_2_i      (rec_2_i),
        .pair_ready_i (pair_ready_i),
        .pair_valid_o (pair_valid_o),
        .rec_1_o      (rec_1_o),
        .rec_2_o      (rec_2_o),
        .stall_1_o    (stall_1_o),
        .stall_2_o    (stall_2_o),
        .skew_o       (skew_o),
        .drained_o    (drained_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] mk(input int n);
        return {32'(32'h1000_0000 + n), 32'(32'h2000_0000 + n), 32'(32'h3000_0000 + n)};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push1(input logic [95:0] r);
        retire_1_i = 1'b1;
        rec_1_i = r;
        tick();
        retire_1_i = 1'b0;
    endtask

    task automatic push2(input logic [95:0] r);
        retire_2_i = 1'b1;
        rec_2_i = r;
        tick();
        retire_2_i = 1'b0;
    endtask

    task automatic pop_pair(input string tag, input logic [95:0] e1, input logic [95:0] e2);
        chk({tag, "_pv"}, pair_valid_o, 1'b1);
        chk({tag, "_r1"}, rec_1_o, e1);
        chk({tag, "_r2"}, rec_2_o, e2);
        pair_ready_i = 1'b1;
        tick();
        pair_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #2;
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        logic [95:0] r0;
        r0 = 96'h00000013_00000004_00000000;

        // reset state
        #1 rst_i = 1'b1;
        #20;
        chk("rst_pv", pair_valid_o, 1'b0);
        chk("rst_drained", drained_o, 1'b1);
        chk("rst_skew", skew_o, 4'd0);
        chk("rst_ovf", overflow_o, 1'b0);
        chk("rst_stall1", stall_1_o, 1'b0);
        chk("rst_stall2", stall_2_o, 1'b0);
        chk("rst_rec1", rec_1_o, 96'd0);
        chk("rst_rec2", rec_2_o, 96'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        tick();

        // single paired retire with ready held high
        retire_1_i = 1'b1;
        retire_2_i = 1'b1;
        rec_1_i = r0;
        rec_2_i = r0;
        pair_ready_i = 1'b1;
        #2;
        chk("t1_no_fwft_pv", pair_valid_o, 1'b0);
        chk("t1_no_fwft_rec", rec_1_o, 96'd0);
        tick();
        retire_1_i = 1'b0;
        retire_2_i = 1'b0;
        chk("t1_pv", pair_valid_o, 1'b1);
        chk("t1_r1", rec_1_o, r0);
        chk("t1_r2", rec_2_o, r0);
        chk("t1_drained0", drained_o, 1'b0);
        tick();
        pair_ready_i = 1'b0;
        chk("t1_pv_after", pair_valid_o, 1'b0);
        chk("t1_drained1", drained_o, 1'b1);

        // core 1 runs three ahead
        push1(mk(1));
        push1(mk(2));
        push1(mk(3));
        chk("t2_skew", skew_o, 4'd3);
        chk("t2_stall1", stall_1_o, 1'b1);
        chk("t2_stall2", stall_2_o, 1'b0);
        chk("t2_pv", pair_valid_o, 1'b0);
        push2(mk(101));
        chk("t2_skew2", skew_o, 4'd2);
        tick();
        pop_pair("t2_p1", mk(1), mk(101));
        push2(mk(102));
        push2(mk(103));
        chk("t2_skew0", skew_o, 4'd0);
        pop_pair("t2_p2", mk(2), mk(102));
        pop_pair("t2_p3", mk(3), mk(103));
        chk("t2_drained", drained_o, 1'b1);

        // overflow on FIFO 1
        push1(mk(11));
        push1(mk(12));
        push1(mk(13));
        push1(mk(14));
        chk("t3_skew4", skew_o, 4'd4);
        chk("t3_ovf0", overflow_o, 1'b0);
        push1(mk(15));
        chk("t3_ovf1", overflow_o, 1'b1);
        chk("t3_skew_sat", skew_o, 4'd4);
        push2(mk(21));
        push2(mk(22));
        push2(mk(23));
        push2(mk(24));
        pop_pair("t3_p1", mk(11), mk(21));
        pop_pair("t3_p2", mk(12), mk(22));
        pop_pair("t3_p3", mk(13), mk(23));
        pop_pair("t3_p4", mk(14), mk(24));
        chk("t3_drained", drained_o, 1'b1);
        chk("t3_ovf_sticky", overflow_o, 1'b1);

        do_reset();
        chk("rst2_ovf", overflow_o, 1'b0);

        // push into full FIFO 1 on a popping edge
        push1(mk(31));
        push1(mk(32));
        push1(mk(33));
        push1(mk(34));
        push2(mk(41));
        chk("t4_pv", pair_valid_o, 1'b1);
        chk("t4_r1", rec_1_o, mk(31));
        pair_ready_i = 1'b1;
        retire_1_i = 1'b1;
        rec_1_i = mk(35);
        tick();
        pair_ready_i = 1'b0;
        retire_1_i = 1'b0;
        chk("t4_ovf", overflow_o, 1'b0);
        chk("t4_skew", skew_o, 4'd4);
        chk("t4_stall1", stall_1_o, 1'b1);
        push2(mk(42));
        push2(mk(43));
        push2(mk(44));
        chk("t4_skew1", skew_o, 4'd1);
        pop_pair("t4_p2", mk(32), mk(42));
        pop_pair("t4_p3", mk(33), mk(43));
        pop_pair("t4_p4", mk(34), mk(44));
        push2(mk(45));
        pop_pair("t4_p5", mk(35), mk(45));
        chk("t4_drained", drained_o, 1'b1);

        // eight paired iterations wrap both pointers twice
        for (int i = 0; i < 8; i++) begin
            retire_1_i = 1'b1;
            retire_2_i = 1'b1;
            rec_1_i = mk(50 + i);
            rec_2_i = mk(60 + i);
            tick();
            retire_1_i = 1'b0;
            retire_2_i = 1'b0;
            chk($sformatf("t5_skew_%0d", i), skew_o, 4'd0);
            pop_pair($sformatf("t5_p%0d", i), mk(50 + i), mk(60 + i));
        end
        chk("t5_drained", drained_o, 1'b1);

        // asynchronous reset mid-cycle with two records each
        push2(mk(71));
        push2(mk(72));
        chk("t6_skew_neg", skew_o, 4'hE);
        chk("t6_stall2", stall_2_o, 1'b0);
        push1(mk(81));
        push1(mk(82));
        chk("t6_pv_pre", pair_valid_o, 1'b1);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("t6_pv", pair_valid_o, 1'b0);
        chk("t6_drained", drained_o, 1'b1);
        chk("t6_ovf", overflow_o, 1'b0);
        chk("t6_rec1", rec_1_o, 96'd0);
        chk("t6_skew", skew_o, 4'd0);
        #2;
        rst_i = 1'b0;
        tick();
        chk("t6_pv_post", pair_valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
